alu_seq_ctrl: RTL and testbench

- Sequencer for the bit-serial `alu`.
- Accepts parallel operands plus opcode over a valid/ready handshake, then clears the ALU carry state with one reset cycle.
- Streams operands LSB-first for WIDTH cycles and collects the serial result into a parallel word, returned over a second valid/ready handshake.
- Sits between a parallel requester (e.g. CPU execute stage) and one `alu` instance driven through the alu_* ports.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU and its sequencer:
// opcode constants, sequencer FSM state encoding and default operand width.
package alu_pkg;

  // Default operand/result width; also the number of serial cycles per op.
  localparam int DEFAULT_WIDTH = 8;

  // Opcodes understood by the serial alu.
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOTA = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True for the opcode that has no ALU meaning.
  function automatic logic is_reserved(input logic [2:0] op);
    return op == OP_RSVD;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequencer for the bit-serial alu.
// Accepts parallel operands, clears the alu carry for one cycle, streams the
// operands LSB-first for WIDTH cycles and gathers the serial result into a
// parallel word returned over a valid/ready handshake.
// Optional build macro ALU_SEQ_FLAGS_EN adds the out_zero result flag.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err,
`ifdef ALU_SEQ_FLAGS_EN
  output logic             out_zero,
`endif
  output logic             alu_rst,
  output logic [2:0]       alu_opcode,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_y
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [2:0]       r_op;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shift;
`ifdef ALU_SEQ_FLAGS_EN
  logic             r_zero;
`endif

  // Final serial cycle, and the result word as it will look after this cycle.
  assign w_last      = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
  assign w_res_shift = {alu_y, r_res[WIDTH-1:1]};

  // State register; reset aborts any operation straight to IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: one CLEAR cycle, WIDTH SHIFT cycles, DONE until taken.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)  w_state_next = ST_CLEAR;
      ST_CLEAR: w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_state_next = ST_DONE;
      ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Output decode from the current state and the datapath registers.
  always_comb begin
    in_ready   = rst && (r_state == ST_IDLE);
    alu_rst    = rst && (r_state != ST_CLEAR);
    alu_opcode = r_op;
    alu_a      = (r_state == ST_SHIFT) ? r_sa[0] : 1'b0;
    alu_b      = (r_state == ST_SHIFT) ? r_sb[0] : 1'b0;
    out_valid  = (r_state == ST_DONE);
    out_err    = (r_state == ST_DONE) && r_err;
    out_y      = ((r_state == ST_DONE) && !r_err) ? r_res : '0;
`ifdef ALU_SEQ_FLAGS_EN
    out_zero   = (r_state == ST_DONE) && r_zero;
`endif
  end

  // Datapath: operand capture, serial shift, result collection, bit counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_op  <= 3'd0;
`ifdef ALU_SEQ_FLAGS_EN
      r_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sa  <= in_a;
            r_sb  <= in_b;
            r_op  <= in_op;
            r_err <= is_reserved(in_op);
          end
        end
        ST_CLEAR: begin
          r_cnt <= '0;
        end
        ST_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_shift;
          // Counter holds at its last value rather than wrapping.
          if (!w_last) begin
            r_cnt <= r_cnt + 1'b1;
          end
`ifdef ALU_SEQ_FLAGS_EN
          // Flag follows the visible out_y, which is forced to 0 on error.
          if (w_last) begin
            r_zero <= r_err || (w_res_shift == '0);
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural serial alu beside it.
// Honours ALU_SEQ_FLAGS_EN to also check out_zero.
module tb_alu_seq_ctrl;
  localparam int W   = 8;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_err;
`ifdef ALU_SEQ_FLAGS_EN
  logic         out_zero;
`endif
  logic         alu_rst;
  logic [2:0]   alu_opcode;
  logic         alu_a;
  logic         alu_b;
  logic         alu_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_err    (out_err),
`ifdef ALU_SEQ_FLAGS_EN
    .out_zero   (out_zero),
`endif
    .alu_rst    (alu_rst),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y)
  );

  // Behavioural bit-serial alu: carry/borrow bit cleared by alu_rst low.
  logic alu_c;
  always_comb begin
    case (alu_opcode)
      3'd0, 3'd1: alu_y = alu_a ^ alu_b ^ alu_c;
      3'd2:       alu_y = alu_a | alu_b;
      3'd3:       alu_y = alu_a & alu_b;
      3'd4:       alu_y = alu_a ^ alu_b;
      3'd5:       alu_y = ~alu_a;
      3'd6:       alu_y = ~(alu_a ^ alu_b);
      default:    alu_y = 1'b0;
    endcase
  end
  always @(posedge clk) begin
    if (!alu_rst) alu_c <= 1'b0;
    else if (alu_opcode == 3'd0) alu_c <= (alu_a & alu_b) | (alu_a & alu_c) | (alu_b & alu_c);
    else if (alu_opcode == 3'd1) alu_c <= (~alu_a & alu_b) | (~(alu_a ^ alu_b) & alu_c);
  end

  // Word-level reference: what the sequenced operation should return.
  function automatic logic [W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned m;
    m = (1 << W) - 1;
    case (op)
      3'd0:    return W'((int'(a) + int'(b)) & m);
      3'd1:    return W'((int'(a) - int'(b) + (1 << W)) & m);
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue one request (out_ready assumed 1) and return the result and latency.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] y, output logic err, output logic z, output int lat);
    int n;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    y   = out_y;
    err = out_err;
`ifdef ALU_SEQ_FLAGS_EN
    z = out_zero;
`else
    z = 1'b0;
`endif
    $display("op=%0d a=%h b=%h -> y=%h err=%0d lat=%0d", op, a, b, y, err, lat);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [W-1:0] y;
    logic         err;
    logic         z;
    int           lat;
    logic         seen;

    vecs[0] = '{3'd0, 8'h5A, 8'h3C, 8'h96, 1'b0};
    vecs[1] = '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[2] = '{3'd1, 8'h10, 8'h01, 8'h0F, 1'b0};
    vecs[3] = '{3'd2, 8'hF0, 8'hAA, 8'hFA, 1'b0};
    vecs[4] = '{3'd4, 8'hF0, 8'hAA, 8'h5A, 1'b0};
    vecs[5] = '{3'd5, 8'hF0, 8'hAA, 8'h0F, 1'b0};
    vecs[6] = '{3'd6, 8'hF0, 8'hAA, 8'hA5, 1'b0};
    vecs[7] = '{3'd3, 8'hF0, 8'hAA, 8'hA0, 1'b0};
    vecs[8] = '{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1};

    rst = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu_rst", alu_rst, 0);
    rst = 1'b1; #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_out_y", out_y, 0);
    chk("post_rst_out_err", out_err, 0);
    chk("post_rst_alu_opcode", alu_opcode, 0);
    chk("post_rst_alu_a", alu_a, 0);
    chk("post_rst_alu_b", alu_b, 0);
    chk("post_rst_alu_rst", alu_rst, 1);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, y, err, z, lat);
      chk($sformatf("vec%0d_y", i), y, vecs[i].y);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_lat", i), lat, LAT);
`ifdef ALU_SEQ_FLAGS_EN
      chk($sformatf("vec%0d_zero", i), z, (vecs[i].y == 0) || vecs[i].err);
`endif
    end

    // Backpressure: result held for 5 cycles with a second request pending.
    out_ready = 1'b0;
    in_op = 3'd0; in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
    chk("bp_first_ready", in_ready, 1);
    @(negedge clk);
    in_a = 8'h20; in_b = 8'h03;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("bp_lat", lat, LAT);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid_held", out_valid, 1);
      chk("bp_y_held", out_y, 8'h46);
      chk("bp_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    $display("op=0 a=12 b=34 -> y=46 held under backpressure");
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_hs", in_ready, 1);
    chk("bp_valid_dropped", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_accepted", in_ready, 0);
    chk("bp_clear_alu_rst", alu_rst, 0);
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("bp2_lat", lat, LAT);
    chk("bp2_y", out_y, 8'h23);
    $display("op=0 a=20 b=03 -> y=%h lat=%0d", out_y, lat);
    @(negedge clk);

    // Reset while shifting, at counter == 3.
    in_op = 3'd0; in_a = 8'hFF; in_b = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0; #1;
    chk("midrst_alu_rst", alu_rst, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("midrst_no_valid", out_valid, 0);
    rst = 1'b1; #1;
    chk("midrst_idle", in_ready, 1);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("midrst_discarded", seen, 0);
    run_op(3'd0, 8'h01, 8'h01, y, err, z, lat);
    chk("midrst_fresh_y", y, 8'h02);
    chk("midrst_fresh_lat", lat, LAT);

    // Randomised operations against the word-level model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      run_op(op, a, b, y, err, z, lat);
      chk("rand_y", y, ref_y(op, a, b));
      chk("rand_err", err, op == 3'd7);
      chk("rand_lat", lat, LAT);
`ifdef ALU_SEQ_FLAGS_EN
      chk("rand_zero", z, ref_y(op, a, b) == 0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
